// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: MM:SS BCD count with run/pause, lap freeze and clear.
module stopwatch_ctrl #(
  parameter int unsigned TICK_DIV = 100000000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start_stop,
  input  logic        lap,
  input  logic        clear,
  output logic [15:0] disp,
  output logic        running,
  output logic        lap_active,
  output logic        rollover
);

  localparam int unsigned PRE_W = 27;
  localparam int unsigned CNT_W = 16;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = 16'h9959;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [PRE_W-1:0] pre, pre_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [CNT_W-1:0] lap_reg, lap_nxt;
  logic             lap_act_nxt;
  logic             roll_nxt;
  logic             tick_c;

  // Increment a {min_tens, min_ones, sec_tens, sec_ones} BCD value, wrapping 99:59 -> 00:00.
  function automatic logic [CNT_W-1:0] bcd_inc(input logic [CNT_W-1:0] c);
    logic [3:0] d0, d1, d2, d3;
    {d3, d2, d1, d0} = c;
    if (d0 != 4'd9) begin
      d0 = d0 + 4'd1;
    end else begin
      d0 = 4'd0;
      if (d1 != 4'd5) begin
        d1 = d1 + 4'd1;
      end else begin
        d1 = 4'd0;
        if (d2 != 4'd9) begin
          d2 = d2 + 4'd1;
        end else begin
          d2 = 4'd0;
          if (d3 != 4'd9) d3 = d3 + 4'd1;
          else            d3 = 4'd0;
        end
      end
    end
    return {d3, d2, d1, d0};
  endfunction

  // Tick is decided from the current state only, so a coincident start_stop still counts.
  assign tick_c = (state == RUN) && (pre == PRE_LAST);

  // Next-state and datapath update; clear overrides every other event.
  always_comb begin
    state_nxt   = state;
    pre_nxt     = pre;
    cnt_nxt     = cnt;
    lap_nxt     = lap_reg;
    lap_act_nxt = lap_active;
    roll_nxt    = 1'b0;
    if (clear) begin
      state_nxt   = IDLE;
      pre_nxt     = '0;
      cnt_nxt     = '0;
      lap_nxt     = '0;
      lap_act_nxt = 1'b0;
    end else begin
      if (state == RUN) begin
        if (tick_c) begin
          pre_nxt  = '0;
          cnt_nxt  = bcd_inc(cnt);
          roll_nxt = (cnt == CNT_MAX);
        end else begin
          pre_nxt = pre + PRE_W'(1);
        end
      end
      if (start_stop) begin
        unique case (state)
          IDLE:    state_nxt = RUN;
          RUN:     state_nxt = PAUSE;
          PAUSE:   state_nxt = RUN;
          default: state_nxt = IDLE;
        endcase
      end
      // Capture takes the pre-increment count, even on a tick edge.
      if (lap && (state != IDLE)) begin
        if (!lap_active) begin
          lap_act_nxt = 1'b1;
          lap_nxt     = cnt;
        end else begin
          lap_act_nxt = 1'b0;
        end
      end
    end
  end

  // State, datapath and registered outputs; disp/running track the values being loaded.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      pre        <= '0;
      cnt        <= '0;
      lap_reg    <= '0;
      lap_active <= 1'b0;
      rollover   <= 1'b0;
      running    <= 1'b0;
      disp       <= '0;
    end else begin
      state      <= state_nxt;
      pre        <= pre_nxt;
      cnt        <= cnt_nxt;
      lap_reg    <= lap_nxt;
      lap_active <= lap_act_nxt;
      rollover   <= roll_nxt;
      running    <= (state_nxt == RUN);
      disp       <= lap_act_nxt ? lap_nxt : cnt_nxt;
    end
  end

endmodule
